// File: rtl/alu_gray_pkg.sv
// Shared types and helpers for the Gray-coded ALU issuer.
// Request bundle, opcode type, FSM states and the binary-to-Gray encoder.
package alu_gray_pkg;

  localparam int ALU_W     = 4;
  localparam int REQ_DEPTH = 2;

  typedef logic [1:0] alu_op_t;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    alu_op_t          op;
  } alu_req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RESP
  } iss_state_t;

  function automatic logic [ALU_W-1:0] bin2gray(
    input logic [ALU_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Two-entry request FIFO with 1-bit wrapping pointers.
// Pushes into a full FIFO and pops from an empty one are ignored.
module alu_req_fifo
  import alu_gray_pkg::*;
#(
  parameter int DEPTH = REQ_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  alu_req_t din_i,
  input  logic     pop_i,
  output alu_req_t dout_o,
  output logic     full_o,
  output logic     empty_o
);

  alu_req_t   mem_q [DEPTH];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic       push_ok;
  logic       pop_ok;

  assign full_o  = (cnt_q == 2'(DEPTH));
  assign empty_o = (cnt_q == 2'd0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_gray_issuer.sv
// Issuer front-end for the Gray-coded ALU core: FIFO, drive, response.
// Optional overflow counter enabled by ALU_GRAY_ISSUER_STATS_EN.
module alu_gray_issuer
  import alu_gray_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int DEPTH = REQ_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_op,
  output logic [W-1:0] alu_g1,
  output logic [W-1:0] alu_g2,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_r,
  input  logic         alu_zero,
  input  logic         alu_ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_rg,
  output logic         out_zero,
  output logic         out_ovf
`ifdef ALU_GRAY_ISSUER_STATS_EN
  ,
  output logic [7:0]   ovf_count
`endif
);

  iss_state_t   state_q, state_d;
  alu_req_t     req_in;
  alu_req_t     head;
  logic         full;
  logic         empty;
  logic         pop;
  logic         load;
  logic         cap;
  logic         ov_q, ov_d;
  logic [W-1:0] g1_q, g2_q, rg_q;
  alu_op_t      op_q;
  logic         zero_q, ovf_q;

  assign req_in = '{a: in_a, b: in_b, op: in_op};

  alu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .din_i   (req_in),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    ov_d    = ov_q;
    pop     = 1'b0;
    load    = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        cap     = 1'b1;
        ov_d    = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          ov_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_d = S_DRIVE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ov_q    <= 1'b0;
      g1_q    <= '0;
      g2_q    <= '0;
      op_q    <= '0;
      rg_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      if (load) begin
        g1_q <= bin2gray(head.a);
        g2_q <= bin2gray(head.b);
        op_q <= head.op;
      end
      if (cap) begin
        rg_q   <= bin2gray(alu_r);
        zero_q <= alu_zero;
        ovf_q  <= alu_ovf;
      end
    end
  end

`ifdef ALU_GRAY_ISSUER_STATS_EN
  logic [7:0] ovc_q;

  // Saturates so a long overflow burst never wraps back to a small count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovc_q <= 8'd0;
    end else if (ov_q && out_ready && ovf_q && ovc_q != 8'hFF) begin
      ovc_q <= ovc_q + 8'd1;
    end
  end

  assign ovf_count = ovc_q;
`else
`endif

  assign in_ready  = !full;
  assign out_valid = ov_q;
  assign alu_g1    = g1_q;
  assign alu_g2    = g2_q;
  assign alu_op    = op_q;
  assign out_rg    = rg_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_gray_issuer.sv
// Directed bench for alu_gray_issuer with a behavioural ALU core model.
// Covers latency, backpressure, streaming order, zero flag and reset.
module tb_alu_gray_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic [1:0] in_op;
  logic [3:0] alu_g1, alu_g2;
  logic [1:0] alu_op;
  logic [3:0] alu_r;
  logic       alu_zero, alu_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_rg;
  logic       out_zero, out_ovf;
`ifdef ALU_GRAY_ISSUER_STATS_EN
  logic [7:0] ovf_count;
`endif

  always #5 clk = ~clk;

  alu_gray_issuer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .alu_g1    (alu_g1),
    .alu_g2    (alu_g2),
    .alu_op    (alu_op),
    .alu_r     (alu_r),
    .alu_zero  (alu_zero),
    .alu_ovf   (alu_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rg    (out_rg),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
`ifdef ALU_GRAY_ISSUER_STATS_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  // ALU core model: fixed answer or add/sub/and/or on decoded operands
  logic       fixed_mode;
  logic [3:0] fix_r;
  logic       fix_z, fix_o;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    logic [3:0] a, b;
    logic [4:0] s;
    a = g2b(alu_g1);
    b = g2b(alu_g2);
    s = '0;
    case (alu_op)
      2'd0:    s = {1'b0, a} + {1'b0, b};
      2'd1:    s = {1'b0, a} - {1'b0, b};
      2'd2:    s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    alu_r    = fixed_mode ? fix_r : s[3:0];
    alu_zero = fixed_mode ? fix_z : (s[3:0] == 4'd0);
    alu_ovf  = fixed_mode ? fix_o : s[4];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] rg;
    logic       z;
    logic       o;
    int         cyc;
  } rsp_t;
  rsp_t rq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && out_valid && out_ready)
      rq.push_back('{out_rg, out_zero, out_ovf, cyc});

  typedef struct {
    logic [3:0] a, b;
    logic [1:0] op;
    logic [3:0] g1, g2, rg;
    logic       z, o;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("push_timeout", 1, 0);
  endtask

  task automatic wait_rsp(input int n);
    for (int t = 0; t < 60 && rq.size() < n; t++) tick();
    chk("rsp_count", rq.size(), n);
  endtask

  initial begin
    // a, b, op, gray(a), gray(b), gray(result), zero, ovf
    vt[0] = '{4'd9,  4'd9,  2'd0, 4'b1101, 4'b1101, 4'b0011, 1'b0, 1'b1};
    vt[1] = '{4'd12, 4'd10, 2'd1, 4'b1010, 4'b1111, 4'b0011, 1'b0, 1'b0};
    vt[2] = '{4'd4,  4'd6,  2'd1, 4'b0110, 4'b0101, 4'b1001, 1'b0, 1'b1};
    vt[3] = '{4'd6,  4'd9,  2'd2, 4'b0101, 4'b1101, 4'b0000, 1'b1, 1'b0};
    vt[4] = '{4'd15, 4'd0,  2'd3, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0};
    vt[5] = '{4'd1,  4'd14, 2'd0, 4'b0001, 4'b1001, 4'b1000, 1'b0, 1'b0};
    vt[6] = '{4'd7,  4'd7,  2'd1, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_op      = '0;
    out_ready  = 1'b0;
    fixed_mode = 1'b1;
    fix_r      = 4'b1000;
    fix_z      = 1'b0;
    fix_o      = 1'b1;
    repeat (3) tick();

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_g1", alu_g1, 0);
    chk("rst_g2", alu_g2, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_rg", out_rg, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_ovf", out_ovf, 0);
    rst_n = 1'b1;
    tick();

    // latency with fixed ALU answer 1000 / Z0 / O1
    push(4'd3, 4'd5, 2'd0);
    chk("lat_valid_n", out_valid, 0);
    tick();
    chk("lat_g1", alu_g1, 4'b0010);
    chk("lat_g2", alu_g2, 4'b0111);
    chk("lat_op", alu_op, 2'b00);
    chk("lat_valid_n1", out_valid, 0);
    tick();
    chk("lat_valid_n2", out_valid, 1);
    chk("lat_rg", out_rg, 4'b1100);
    chk("lat_ovf", out_ovf, 1);
    chk("lat_zero", out_zero, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("lat_drop", out_valid, 0);

    // table: one request at a time with the computing ALU model
    fixed_mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push(vt[i].a, vt[i].b, vt[i].op);
      tick();
      chk($sformatf("v%0d_g1", i), alu_g1, vt[i].g1);
      chk($sformatf("v%0d_g2", i), alu_g2, vt[i].g2);
      chk($sformatf("v%0d_op", i), alu_op, vt[i].op);
      tick();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_rg", i), out_rg, vt[i].rg);
      chk($sformatf("v%0d_zero", i), out_zero, vt[i].z);
      chk($sformatf("v%0d_ovf", i), out_ovf, vt[i].o);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("v%0d_clr", i), out_valid, 0);
    end

    // backpressure: three requests, FIFO fills, output held
    rq.delete();
    push(vt[0].a, vt[0].b, vt[0].op);
    push(vt[1].a, vt[1].b, vt[1].op);
    push(vt[2].a, vt[2].b, vt[2].op);
    chk("bp_full", in_ready, 0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_rg_hold", out_rg, vt[0].rg);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_ready_back", in_ready, 1);
    wait_rsp(3);
    for (int i = 0; i < 3 && i < rq.size(); i++) begin
      chk($sformatf("bp_rg%0d", i), rq[i].rg, vt[i].rg);
      chk($sformatf("bp_ovf%0d", i), rq[i].o, vt[i].o);
    end
    tick();

    // streaming with out_ready held high
    rq.delete();
    for (int i = 0; i < 4; i++) push(vt[i].a, vt[i].b, vt[i].op);
    wait_rsp(4);
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      chk($sformatf("st_rg%0d", i), rq[i].rg, vt[i].rg);
      chk($sformatf("st_zero%0d", i), rq[i].z, vt[i].z);
      if (i > 0)
        chk($sformatf("st_gap%0d", i), rq[i].cyc - rq[i-1].cyc, 2);
    end
    tick();

    // reset while driving with one request still queued
    rq.delete();
    push(vt[4].a, vt[4].b, vt[4].op);
    push(vt[5].a, vt[5].b, vt[5].op);
    chk("rs_in_drive", out_valid, 0);
    rst_n = 1'b0;
    tick();
    chk("rs_valid", out_valid, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_g1", alu_g1, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("rs_no_result", rq.size(), 0);
    chk("rs_idle_valid", out_valid, 0);

`ifdef ALU_GRAY_ISSUER_STATS_EN
    chk("stat_rst", ovf_count, 0);
    fixed_mode = 1'b1;
    fix_r      = 4'd5;
    fix_z      = 1'b0;
    fix_o      = 1'b1;
    out_ready  = 1'b1;
    for (int i = 0; i < 300; i++) push(4'd1, 4'd2, 2'd0);
    repeat (10) tick();
    chk("stat_sat", ovf_count, 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
